// File: rtl/axis_packet_rr_arbiter_if.sv
// Stream bundle for the packet arbiter: NUM_PORTS ingress streams plus one merged egress stream.
// The master modport is the arbiter's view; slave is the sources/sink side.
interface axis_packet_rr_arbiter_if #(
    parameter int TDATA_WIDTH = 32,
    parameter int NUM_PORTS   = 4
);
    localparam int PORT_W = $clog2(NUM_PORTS);

    logic [NUM_PORTS*TDATA_WIDTH-1:0] s_axis_tdata;
    logic [NUM_PORTS-1:0]             s_axis_tlast;
    logic [NUM_PORTS-1:0]             s_axis_tvalid;
    logic [NUM_PORTS-1:0]             s_axis_tready;
    logic [TDATA_WIDTH-1:0]           m_axis_tdata;
    logic                             m_axis_tlast;
    logic [PORT_W-1:0]                m_axis_tid;
    logic                             m_axis_tvalid;
    logic                             m_axis_tready;

    modport master (
        input  s_axis_tdata, s_axis_tlast, s_axis_tvalid,
        output s_axis_tready,
        output m_axis_tdata, m_axis_tlast, m_axis_tid, m_axis_tvalid,
        input  m_axis_tready
    );

    modport slave (
        output s_axis_tdata, s_axis_tlast, s_axis_tvalid,
        input  s_axis_tready,
        input  m_axis_tdata, m_axis_tlast, m_axis_tid, m_axis_tvalid,
        output m_axis_tready
    );
endinterface

// File: rtl/axis_packet_rr_arbiter.sv
// Packet-granular round-robin merge of NUM_PORTS AXI-Stream sources; a grant is held
// until the granted source's tlast beat is accepted downstream.
module axis_packet_rr_arbiter #(
    parameter int TDATA_WIDTH = 32,
    parameter int NUM_PORTS   = 4
) (
    input  logic                      clk,
    input  logic                      resetn,
    axis_packet_rr_arbiter_if.master  bus,
    output logic [31:0]               pkt_count
);
    localparam int PORT_W = $clog2(NUM_PORTS);

    typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

    state_t               state, state_nx;
    logic [PORT_W-1:0]    grant, grant_nx;
    logic [PORT_W-1:0]    last_grant, last_grant_nx;
    logic [PORT_W-1:0]    pick;
    logic [31:0]          pkt_count_nx;
    logic                 found;
    logic                 locked;
    logic                 eop;
    logic [NUM_PORTS-1:0] ready_vec;
    int                   idx;

    // Search starts one past the last winner; only indices < NUM_PORTS are visited,
    // so unused encodings can never be granted.
    always_comb begin
        pick  = grant;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            idx = (int'(last_grant) + k) % NUM_PORTS;
            if (!found && bus.s_axis_tvalid[idx]) begin
                found = 1'b1;
                pick  = PORT_W'(idx);
            end
        end
    end

    assign locked = (state == LOCKED);

    // Output valid depends only on state and the source valid, never on m_axis_tready.
    assign bus.m_axis_tdata  = bus.s_axis_tdata[int'(grant)*TDATA_WIDTH +: TDATA_WIDTH];
    assign bus.m_axis_tlast  = bus.s_axis_tlast[grant];
    assign bus.m_axis_tid    = grant;
    assign bus.m_axis_tvalid = locked & bus.s_axis_tvalid[grant];

    always_comb begin
        ready_vec        = '0;
        ready_vec[grant] = locked & bus.m_axis_tready;
    end
    assign bus.s_axis_tready = ready_vec;

    assign eop = bus.m_axis_tvalid & bus.m_axis_tready & bus.m_axis_tlast;

    always_comb begin
        state_nx      = state;
        grant_nx      = grant;
        last_grant_nx = last_grant;
        pkt_count_nx  = pkt_count;
        case (state)
            IDLE: begin
                if (found) begin
                    grant_nx = pick;
                    state_nx = LOCKED;
                end
            end
            LOCKED: begin
                if (eop) begin
                    last_grant_nx = grant;
                    state_nx      = IDLE;
                    pkt_count_nx  = pkt_count + 32'd1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= PORT_W'(NUM_PORTS - 1);
            pkt_count  <= '0;
        end else begin
            state      <= state_nx;
            grant      <= grant_nx;
            last_grant <= last_grant_nx;
            pkt_count  <= pkt_count_nx;
        end
    end
endmodule

// File: tb/tb_axis_packet_rr_arbiter.sv
// Directed bench: per-port source queues feed the arbiter, a scoreboard of expected
// merged beats (in the required arbitration order) is checked at each m_axis handshake.
module tb_axis_packet_rr_arbiter;
    localparam int DW = 32;
    localparam int NP = 4;

    typedef struct packed { logic [31:0] data; logic last; } beat_t;
    typedef struct packed { logic [31:0] data; logic last; logic [1:0] tid; } exp_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [31:0] pkt_count;
    logic [NP-1:0] en = '0;

    beat_t src_q [NP][$];
    exp_t  exp_q [$];

    int checks = 0;
    int errors = 0;

    axis_packet_rr_arbiter_if #(.TDATA_WIDTH(DW), .NUM_PORTS(NP)) bus ();

    axis_packet_rr_arbiter #(.TDATA_WIDTH(DW), .NUM_PORTS(NP)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .bus       (bus),
        .pkt_count (pkt_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic drive();
        for (int p = 0; p < NP; p++) begin
            if (en[p] && src_q[p].size() != 0) begin
                bus.s_axis_tvalid[p]           = 1'b1;
                bus.s_axis_tdata[p*DW +: DW]   = src_q[p][0].data;
                bus.s_axis_tlast[p]            = src_q[p][0].last;
            end else begin
                bus.s_axis_tvalid[p]           = 1'b0;
                bus.s_axis_tdata[p*DW +: DW]   = '0;
                bus.s_axis_tlast[p]            = 1'b0;
            end
        end
    endtask

    // Queue one packet on source p and record its beats as expected output.
    task automatic load(input int p, input int n, input logic [31:0] base);
        beat_t b;
        exp_t  e;
        for (int i = 0; i < n; i++) begin
            b.data = base + 32'(i);
            b.last = (i == n - 1);
            src_q[p].push_back(b);
            e.data = b.data;
            e.last = b.last;
            e.tid  = 2'(p);
            exp_q.push_back(e);
        end
    endtask

    task automatic sb_pop();
        exp_t e;
        checks++;
        assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL sb_extra observed tid=%0d data=%0h expected=none",
                   bus.m_axis_tid, bus.m_axis_tdata);
        end
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("sb_data", 64'(bus.m_axis_tdata), 64'(e.data));
            chk("sb_last", 64'(bus.m_axis_tlast), 64'(e.last));
            chk("sb_tid",  64'(bus.m_axis_tid),   64'(e.tid));
        end
    endtask

    // One clock: sample handshakes at negedge, retire accepted source beats after posedge.
    task automatic tick();
        logic [NP-1:0] hs;
        @(negedge clk);
        hs = bus.s_axis_tvalid & bus.s_axis_tready;
        if (bus.m_axis_tvalid && bus.m_axis_tready) sb_pop();
        @(posedge clk);
        #1;
        for (int p = 0; p < NP; p++)
            if (hs[p] && src_q[p].size() != 0) void'(src_q[p].pop_front());
        drive();
        #1;
    endtask

    task automatic wait_empty(input string tag, input int budget, output int n);
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        chk(tag, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic clear_all();
        for (int p = 0; p < NP; p++) src_q[p].delete();
        exp_q.delete();
        en = '0;
        drive();
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        bus.m_axis_tready = 1'b0;
        clear_all();
        #1;
        chk("rst_m_tvalid", 64'(bus.m_axis_tvalid), 64'd0);
        chk("rst_s_tready", 64'(bus.s_axis_tready), 64'd0);
        chk("rst_pkt_count", 64'(pkt_count), 64'd0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        #1;
    endtask

    initial begin
        int n;
        bus.m_axis_tready = 1'b0;
        drive();
        do_reset();

        // Lone source, 3-beat packet: one bubble then three beats with tid 2.
        bus.m_axis_tready = 1'b1;
        load(2, 3, 32'hA0);
        en[2] = 1'b1;
        drive();
        #1;
        chk("t1_bubble", 64'(bus.m_axis_tvalid), 64'd0);
        tick();
        chk("t1_first_valid", 64'(bus.m_axis_tvalid), 64'd1);
        chk("t1_first_tid", 64'(bus.m_axis_tid), 64'd2);
        chk("t1_first_data", 64'(bus.m_axis_tdata), 64'hA0);
        wait_empty("t1_drain", 20, n);
        chk("t1_pkt_count", 64'(pkt_count), 64'd1);

        // All ports busy with 2-beat packets: strict 0,1,2,3 rotation at 3 cycles/packet.
        do_reset();
        bus.m_axis_tready = 1'b1;
        for (int r = 0; r < 2; r++)
            for (int p = 0; p < NP; p++)
                load(p, 2, 32'h1000 + 32'(p << 8) + 32'(r << 4));
        en = '1;
        drive();
        wait_empty("t2_drain", 60, n);
        chk("t2_cycles", 64'(n), 64'd24);
        chk("t2_pkt_count", 64'(pkt_count), 64'd8);

        // Port 1 mid-packet when ports 0 and 2 arrive: no preemption, 2 before 0.
        clear_all();
        load(1, 5, 32'h2100);
        en[1] = 1'b1;
        drive();
        tick();
        tick();
        load(2, 2, 32'h2200);
        load(0, 2, 32'h2000);
        en[0] = 1'b1;
        en[2] = 1'b1;
        drive();
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("t3_ready0_low", 64'(bus.s_axis_tready[0]), 64'd0);
            chk("t3_tid_held", 64'(bus.m_axis_tid), 64'd1);
            tick();
        end
        wait_empty("t3_drain", 30, n);

        // Port 3 with downstream ready toggling: ready mirrored, no loss or duplication.
        clear_all();
        load(3, 4, 32'h3300);
        en[3] = 1'b1;
        drive();
        for (int i = 0; i < 30 && exp_q.size() != 0; i++) begin
            bus.m_axis_tready = ~i[0];
            #1;
            if (bus.m_axis_tvalid)
                chk("t4_ready_mirror", 64'(bus.s_axis_tready), 64'({bus.m_axis_tready, 3'b000}));
            tick();
        end
        chk("t4_drain", 64'(exp_q.size()), 64'd0);
        bus.m_axis_tready = 1'b1;

        // Granted port 0 stalls 3 cycles mid-packet; port 1 must wait.
        clear_all();
        load(0, 4, 32'h4000);
        load(1, 2, 32'h4100);
        en[0] = 1'b1;
        en[1] = 1'b1;
        drive();
        tick();
        tick();
        tick();
        en[0] = 1'b0;
        drive();
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("t5_stall_valid", 64'(bus.m_axis_tvalid), 64'd0);
            chk("t5_port1_wait", 64'(bus.s_axis_tready[1]), 64'd0);
            chk("t5_tid_held", 64'(bus.m_axis_tid), 64'd0);
            tick();
        end
        en[0] = 1'b1;
        drive();
        wait_empty("t5_drain", 30, n);

        // Reset during beat 2: outputs and count clear at once; port 0 first afterwards.
        clear_all();
        load(2, 4, 32'h5200);
        en[2] = 1'b1;
        drive();
        tick();
        tick();
        resetn = 1'b0;
        #1;
        chk("t6_rst_m_tvalid", 64'(bus.m_axis_tvalid), 64'd0);
        chk("t6_rst_s_tready", 64'(bus.s_axis_tready), 64'd0);
        chk("t6_rst_pkt_count", 64'(pkt_count), 64'd0);
        clear_all();
        @(posedge clk);
        #1;
        resetn = 1'b1;
        load(0, 1, 32'h6000);
        load(3, 1, 32'h6300);
        en[0] = 1'b1;
        en[3] = 1'b1;
        drive();
        wait_empty("t6_drain", 20, n);
        chk("t6_pkt_count", 64'(pkt_count), 64'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
